qu_uop_queue: RTL and testbench
===============================

QU_UOP_QUEUE -- requirements
Module: qu_uop_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of uop entries; power of two, at least 2.
REQ-002 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port flush  input  1  discard all entries (branch/jump/exception redirect).
REQ-005 SHALL have port in_valid  input  1  decode stage presents a uop.
REQ-006 SHALL have port nop  input  1  the presented uop is a NOP.
REQ-007 SHALL have port invalid  input  1  the presented uop is an illegal instruction.
REQ-008 SHALL have port uop_in  input  uop_t  uop from decode.
REQ-009 SHALL have port stall  output  1  back-pressure to decode (drives id_stall).
REQ-010 SHALL have port out_valid  output  1  head entry is valid.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the head this cycle.
REQ-012 SHALL have port uop_out  output  uop_t  head uop.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.
REQ-014 SHALL have port invalid_seen  output  1  sticky flag: an illegal uop was presented.

Function
REQ-015 SHALL accept a uop (push) when in_valid=1, nop=0, invalid=0, stall=0, flush=0.
REQ-016 SHALL silently drop uops with nop=1; no push, no stall effect.
REQ-017 SHALL drop uops with invalid=1 and set invalid_seen on the next edge (invalid takes priority over nop).
REQ-018 SHALL drive stall = (count == DEPTH), combinationally from registered count.
REQ-019 SHALL pop the head when out_valid=1 and out_ready=1 and flush=0.
REQ-020 SHALL drive out_valid = (count != 0) and uop_out = storage[rd_ptr] (without bypass).
REQ-021 SHALL give push-to-out_valid latency of one cycle when bypass is compiled out.
REQ-022 SHALL allow push and pop in the same cycle; count unchanged, both pointers advance.
REQ-023 SHALL wrap rd_ptr and wr_ptr modulo DEPTH using $clog2(DEPTH)-bit pointers.
REQ-024 SHALL never push when full and never pop when empty; count stays in 0..DEPTH.
REQ-025 SHALL on flush=1 set count, rd_ptr, wr_ptr to 0 and clear invalid_seen at the next edge, ignoring any same-cycle push or pop.
REQ-026 SHALL keep invalid_seen set until flush or reset.
REQ-027 SHALL preserve FIFO order: uops leave in exactly the order pushed.

Reset
REQ-028 SHALL on rst=1 immediately clear count, pointers, invalid_seen; out_valid=0, stall=0; storage contents unspecified.
REQ-029 SHALL, when reset asserts mid-operation, discard all held uops; no partial uop is emitted after release.
REQ-030 SHALL accept a push on the first rising edge after rst deasserts.

Configuration
REQ-031 SHALL, with QU_UOPQ_BYPASS_EN defined, forward uop_in combinationally to uop_out with out_valid=1 when count==0 and a push is qualified; if out_ready=1 that cycle the uop is not stored.
REQ-032 SHALL, without QU_UOPQ_BYPASS_EN, have no combinational path from uop_in/in_valid to uop_out/out_valid.

Structure
REQ-033 SHALL take uop_t from package qu_uop and QU_UOPQ_DEPTH (default DEPTH value) from package qu_common.
REQ-034 SHALL be a single module with no sub-modules; storage is a register array of uop_t.

Verification
REQ-035 SHALL cover fill: 8 back-to-back valid uops, out_ready=0 -> count=8, stall=1 after 8th edge; 9th uop held, not lost.
REQ-036 SHALL cover drain/order: then out_ready=1 for 8 cycles -> uops emerge in push order, count reaches 0, out_valid=0.
REQ-037 SHALL cover wrap: 20 pushes with concurrent pops at count=3 -> count stays 3, pointers wrap, order preserved.
REQ-038 SHALL cover filtering: nop=1 and invalid=1 uops interleaved -> neither enqueued; invalid_seen=1 after first invalid.
REQ-039 SHALL cover flush: count=5, flush=1 with simultaneous push and pop -> count=0, invalid_seen=0, out_valid=0 next cycle.
REQ-040 SHALL cover reset mid-stream: rst pulsed at count=4 -> outputs cleared asynchronously, first post-reset push appears one cycle later (same cycle with QU_UOPQ_BYPASS_EN).

Source files
------------

// File: rtl/qu_common.sv
// Shared micro-architectural constants for the front-end queues.
package qu_common;
  localparam int QU_UOPQ_DEPTH = 8;
endpackage

// File: rtl/qu_uop.sv
// Decoded micro-op format passed from decode to issue.
package qu_uop;
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } uop_t;
endpackage

// File: rtl/qu_uop_queue.sv
// Purpose: decode-to-issue uop queue, circular buffer; optional bypass via QU_UOPQ_BYPASS_EN.
// Latency: push visible on out_valid next cycle (same cycle when bypassing an empty queue).
// Backpressure: stall while full; flush overrides any same-cycle push or pop.
module qu_uop_queue
  import qu_common::*;
  import qu_uop::*;
#(
  parameter int DEPTH = QU_UOPQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic                       nop,
  input  logic                       invalid,
  input  uop_t                       uop_in,
  output logic                       stall,
  output logic                       out_valid,
  input  logic                       out_ready,
  output uop_t                       uop_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       invalid_seen
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  uop_t          storage [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push_ok;
  logic          store;
  logic          pop;

  assign stall   = (count == CW'(DEPTH));
  assign push_ok = in_valid & ~nop & ~invalid & ~stall & ~flush;

`ifdef QU_UOPQ_BYPASS_EN
  logic bypass;
  // An empty queue hands the incoming uop straight through; it is only stored if not taken.
  assign bypass    = (count == '0) & push_ok;
  assign out_valid = (count != '0) | bypass;
  assign uop_out   = bypass ? uop_in : storage[rd_ptr];
  assign store     = push_ok & ~(bypass & out_ready);
  assign pop       = (count != '0) & out_ready & ~flush;
`else
  assign out_valid = (count != '0);
  assign uop_out   = storage[rd_ptr];
  assign store     = push_ok;
  assign pop       = out_valid & out_ready & ~flush;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      invalid_seen <= 1'b0;
    end else if (flush) begin
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      invalid_seen <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid & invalid) invalid_seen <= 1'b1;
    end
  end

  // Payload needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (store) storage[wr_ptr] <= uop_in;
  end

endmodule

// File: tb/tb_qu_uop_queue.sv
// Self-checking bench for qu_uop_queue against a queue-based reference model.
module tb_qu_uop_queue;
  import qu_uop::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       nop = 1'b0;
  logic       invalid = 1'b0;
  uop_t       uop_in = '0;
  logic       stall;
  logic       out_valid;
  logic       out_ready = 1'b0;
  uop_t       uop_out;
  logic [3:0] count;
  logic       invalid_seen;

  int total = 0;
  int bad = 0;

  // Reference model state
  uop_t mq[$];
  bit   mseen = 1'b0;

  // Per-cycle observations filled by tick
  logic got_vld, got_stall;
  uop_t got_uop;
  bit   exp_vld, exp_stall, did_pop;
  uop_t exp_uop;

  qu_uop_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .nop(nop),
    .invalid(invalid), .uop_in(uop_in), .stall(stall), .out_valid(out_valid),
    .out_ready(out_ready), .uop_out(uop_out), .count(count),
    .invalid_seen(invalid_seen)
  );

  always #5 clk = ~clk;

  function automatic uop_t rand_uop();
    uop_t u;
    u.pc  = $urandom;
    u.op  = 8'($urandom);
    u.rd  = 5'($urandom);
    u.rs1 = 5'($urandom);
    u.rs2 = 5'($urandom);
    return u;
  endfunction

  // Drive one cycle of inputs, capture pre-edge outputs, advance the model, settle past the edge.
  task automatic tick(input logic iv, input logic n, input logic inv, input uop_t u,
                      input logic rdy, input logic fl);
    bit push;
    int sz;
    @(negedge clk);
    in_valid = iv; nop = n; invalid = inv; uop_in = u; out_ready = rdy; flush = fl;
    #1;
    got_vld = out_valid; got_uop = uop_out; got_stall = stall;
    sz = mq.size();
    exp_stall = (sz == DEPTH);
    exp_vld = (sz != 0);
    exp_uop = (sz != 0) ? mq[0] : '0;
    push = iv && !n && !inv && (sz < DEPTH) && !fl;
`ifdef QU_UOPQ_BYPASS_EN
    if (sz == 0 && push) begin exp_vld = 1'b1; exp_uop = u; end
`endif
    did_pop = exp_vld && rdy && !fl;
    if (fl) begin
      mq.delete();
      mseen = 1'b0;
    end else begin
      if (iv && inv) mseen = 1'b1;
      if (did_pop) begin
        if (sz != 0) mq.delete(0);
        else push = 1'b0;
      end
      if (push) mq.push_back(u);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; nop = 1'b0; invalid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (count !== 4'd0 || out_valid !== 1'b0 || stall !== 1'b0 || invalid_seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: count=%0d out_valid=%b stall=%b invalid_seen=%b, want 0/0/0/0",
               count, out_valid, stall, invalid_seen);
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    uop_t held;
    for (int i = 0; i < DEPTH; i++) tick(1, 0, 0, rand_uop(), 0, 0);
    total++;
    if (count !== 4'd8 || stall !== 1'b1) begin
      bad++;
      $display("FAIL fill_full: count=%0d stall=%b, want 8/1", count, stall);
    end
    held = rand_uop();
    tick(1, 0, 0, held, 0, 0);
    total++;
    if (int'(count) !== mq.size() || got_stall !== 1'b1) begin
      bad++;
      $display("FAIL fill_ninth: count=%0d stall=%b, want %0d/1", count, got_stall, mq.size());
    end
    for (int i = 0; i < DEPTH; i++) begin
      tick(0, 0, 0, '0, 1, 0);
      total++;
      if (got_vld !== 1'b1 || got_uop !== exp_uop) begin
        bad++;
        $display("FAIL drain_order[%0d]: vld=%b uop=%h, want 1/%h", i, got_vld, got_uop, exp_uop);
      end
    end
    total++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty: count=%0d out_valid=%b, want 0/0", count, out_valid);
    end
    // Decode re-presents the stalled uop once space frees up
    tick(1, 0, 0, held, 0, 0);
    tick(0, 0, 0, '0, 1, 0);
    total++;
    if (got_vld !== 1'b1 || got_uop !== held) begin
      bad++;
      $display("FAIL held_uop: vld=%b uop=%h, want 1/%h", got_vld, got_uop, held);
    end
  endtask

  task automatic test_wrap();
    tick(0, 0, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, rand_uop(), 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, 0, rand_uop(), 1, 0);
      total++;
      if (count !== 4'd3 || got_uop !== exp_uop || did_pop !== 1'b1) begin
        bad++;
        $display("FAIL wrap[%0d]: count=%0d uop=%h, want 3/%h", i, count, got_uop, exp_uop);
      end
    end
  endtask

  task automatic test_filter();
    int k;
    tick(0, 0, 0, '0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 3);
      tick(1, k[0], k[1], rand_uop(), 1'($urandom_range(0, 1)), 0);
      total++;
      if (int'(count) !== mq.size() || invalid_seen !== mseen ||
          (did_pop && got_uop !== exp_uop)) begin
        bad++;
        $display("FAIL filter[%0d]: count=%0d seen=%b uop=%h, want %0d/%b/%h",
                 i, count, invalid_seen, got_uop, mq.size(), mseen, exp_uop);
      end
    end
  endtask

  task automatic test_flush();
    tick(0, 0, 0, '0, 0, 1);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, rand_uop(), 0, 0);
    tick(1, 0, 1, rand_uop(), 0, 0);
    total++;
    if (count !== 4'd5 || invalid_seen !== 1'b1) begin
      bad++;
      $display("FAIL flush_setup: count=%0d seen=%b, want 5/1", count, invalid_seen);
    end
    tick(1, 0, 0, rand_uop(), 1, 1);
    total++;
    if (count !== 4'd0 || invalid_seen !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_clear: count=%0d seen=%b vld=%b, want 0/0/0", count, invalid_seen, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    uop_t u;
    for (int i = 0; i < 4; i++) tick(1, 0, i == 1, rand_uop(), 0, 0);
    #2;
    idle_inputs();
    rst = 1'b1;
    #1;
    total++;
    if (count !== 4'd0 || out_valid !== 1'b0 || stall !== 1'b0 || invalid_seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: count=%0d vld=%b stall=%b seen=%b, want 0/0/0/0",
               count, out_valid, stall, invalid_seen);
    end
    mq.delete();
    mseen = 1'b0;
    rst = 1'b0;
    u = rand_uop();
    tick(1, 0, 0, u, 0, 0);
    total++;
    if (got_vld !== exp_vld || out_valid !== 1'b1 || count !== 4'd1) begin
      bad++;
      $display("FAIL reset_first_push: pre_vld=%b vld=%b count=%0d, want %b/1/1",
               got_vld, out_valid, count, exp_vld);
    end
    tick(0, 0, 0, '0, 1, 0);
    total++;
    if (got_uop !== u || count !== 4'd0) begin
      bad++;
      $display("FAIL reset_first_pop: uop=%h count=%0d, want %h/0", got_uop, count, u);
    end
  endtask

  task automatic test_random();
    logic iv, n, inv, rdy, fl;
    for (int i = 0; i < 400; i++) begin
      iv  = 1'($urandom_range(0, 3) != 0);
      n   = 1'($urandom_range(0, 9) == 0);
      inv = 1'($urandom_range(0, 19) == 0);
      rdy = 1'($urandom_range(0, 2) == 0);
      fl  = 1'($urandom_range(0, 39) == 0);
      tick(iv, n, inv, rand_uop(), rdy, fl);
      total++;
      if (got_vld !== exp_vld || got_stall !== exp_stall || (exp_vld && got_uop !== exp_uop) ||
          int'(count) !== mq.size() || invalid_seen !== mseen) begin
        bad++;
        $display("FAIL random[%0d]: vld=%b stall=%b uop=%h count=%0d seen=%b, want %b/%b/%h/%0d/%b",
                 i, got_vld, got_stall, got_uop, count, invalid_seen,
                 exp_vld, exp_stall, exp_uop, mq.size(), mseen);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_filter();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
